// File: rtl/ram_fifo_thresh.sv
// RAM-backed FIFO with level-based almost-full/almost-empty flags and sticky error flags.
// Define RAMFIFO_FWFT_EN to build the first-word-fall-through variant (prefetch output register).
module ram_fifo_thresh #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 4,
    parameter int AF_LEVEL  = 14,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 shift_in,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 shift_out,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rdata_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   level,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] LVL_FULL = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] LVL_AF   = (ADDR_BITS+1)'(AF_LEVEL);
    localparam logic [ADDR_BITS:0] LVL_AE   = (ADDR_BITS+1)'(AE_LEVEL);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [ADDR_BITS:0] r_wr_ptr;
    logic [ADDR_BITS:0] r_rd_ptr;
    logic [ADDR_BITS:0] r_level;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_overflow;
    logic               r_underflow;

    logic w_full;
    logic w_empty;
    logic w_pop_acc;
    logic w_wr_acc;
    logic w_ram_wr;
    logic w_ram_rd;
    logic w_bypass;

    assign w_full    = (r_level == LVL_FULL);
    assign w_empty   = (r_level == '0);
    assign w_pop_acc = shift_out & ~w_empty;
    assign w_wr_acc  = shift_in & (~w_full | w_pop_acc);

`ifdef RAMFIFO_FWFT_EN
    logic w_ram_empty;

    // The output register holds the head word whenever level > 0; the RAM holds the rest.
    // A write that would become the head goes straight into the output register.
    assign w_ram_empty = (r_rd_ptr == r_wr_ptr);
    assign w_bypass    = w_wr_acc & w_ram_empty & (w_empty | w_pop_acc);
    assign w_ram_wr    = w_wr_acc & ~w_bypass;
    assign w_ram_rd    = w_pop_acc & ~w_ram_empty;
    assign rdata_valid = 1'b0;
`else
    logic r_rdata_valid;

    assign w_bypass    = 1'b0;
    assign w_ram_wr    = w_wr_acc;
    assign w_ram_rd    = w_pop_acc;
    assign rdata_valid = r_rdata_valid;

    always_ff @(posedge clk) begin
        if (res) begin
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= w_pop_acc;
        end
    end
`endif

    // Array is never reset; contents are discarded logically through the pointers.
    always_ff @(posedge clk) begin
        if (!res && w_ram_wr) begin
            r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_rdata     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ram_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_ram_rd) begin
                r_rdata  <= r_mem[r_rd_ptr[ADDR_BITS-1:0]];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end else if (w_bypass) begin
                r_rdata <= wdata;
            end

            if (w_wr_acc && !w_pop_acc) begin
                r_level <= r_level + 1'b1;
            end else if (!w_wr_acc && w_pop_acc) begin
                r_level <= r_level - 1'b1;
            end

            // A new error in the same cycle as clr_err wins.
            r_overflow  <= (shift_in & ~w_wr_acc) | (r_overflow & ~clr_err);
            r_underflow <= (shift_out & ~w_pop_acc) | (r_underflow & ~clr_err);
        end
    end

    assign rdata        = r_rdata;
    assign level        = r_level;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= LVL_AF);
    assign almost_empty = (r_level <= LVL_AE);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_ram_fifo_thresh.sv
// Directed and random checks of ram_fifo_thresh against a queue-based reference model.
module tb_ram_fifo_thresh;

    localparam int W     = 8;
    localparam int A     = 4;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic         shift_in = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         shift_out = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] rdata;
    logic         rdata_valid;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [A:0]   level;
    logic         overflow;
    logic         underflow;

    ram_fifo_thresh #(.WIDTH(W), .ADDR_BITS(A), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk          (clk),
        .res          (res),
        .shift_in     (shift_in),
        .wdata        (wdata),
        .shift_out    (shift_out),
        .clr_err      (clr_err),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int           m_level  = 0;
    logic         m_ovf    = 1'b0;
    logic         m_udf    = 1'b0;
    logic         m_rv     = 1'b0;
    logic [W-1:0] m_rdata  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".level"}, 32'(level), 32'(m_level));
        check({tag, ".full"}, 32'(full), 32'(m_level == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(m_level == 0));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(m_level >= 14));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(m_level <= 2));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
`ifdef RAMFIFO_FWFT_EN
        check({tag, ".rdata_valid"}, 32'(rdata_valid), 32'(0));
        if (m_level > 0) check({tag, ".rdata_head"}, 32'(rdata), 32'(exp_q[0]));
`else
        check({tag, ".rdata_valid"}, 32'(rdata_valid), 32'(m_rv));
        check({tag, ".rdata"}, 32'(rdata), 32'(m_rdata));
`endif
    endtask

    task automatic step(input logic wr, input logic [W-1:0] d, input logic rd,
                        input logic clr, input string tag);
        logic pop_ok;
        logic wr_ok;
        pop_ok    = rd && (m_level != 0);
        wr_ok     = wr && ((m_level != DEPTH) || pop_ok);
        shift_in  = wr;
        wdata     = d;
        shift_out = rd;
        clr_err   = clr;
        @(posedge clk);
        #1;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        clr_err   = 1'b0;
        m_rv      = pop_ok;
        if (pop_ok) m_rdata = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(d);
        m_level = m_level + int'(wr_ok) - int'(pop_ok);
        m_ovf   = (wr && !wr_ok) || (m_ovf && !clr);
        m_udf   = (rd && !pop_ok) || (m_udf && !clr);
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        res       = 1'b1;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        clr_err   = 1'b0;
        @(posedge clk);
        #1;
        res = 1'b0;
        exp_q.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_rv    = 1'b0;
        m_rdata = '0;
        check({tag, ".rdata_zero"}, 32'(rdata), 32'(0));
        check_state(tag);
    endtask

    initial begin
        do_reset("reset");

        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        step(1'b1, 8'hEE, 1'b0, 1'b0, "fill_ovf");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr1");
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        step(1'b0, 8'h00, 1'b1, 1'b0, "drain_udf");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr2");

        step(1'b1, 8'h3C, 1'b1, 1'b0, "sim_empty");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr3");
        for (int i = 0; i < 15; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "refill");
        step(1'b1, 8'h5A, 1'b1, 1'b0, "sim_full");
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "wrap_wr");
            for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_rd");
        end

        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "pre_rst_fill");
        step(1'b1, 8'hEE, 1'b0, 1'b0, "pre_rst_ovf");
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "pre_rst_pop");
        do_reset("mid_reset");
        step(1'b1, 8'h77, 1'b0, 1'b0, "post_rst_wr");
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_rd");

        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "coinc_fill");
        step(1'b1, 8'h99, 1'b0, 1'b1, "clr_coinc_ovf");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr_ovf");
        do_reset("reset2");
        step(1'b0, 8'h00, 1'b1, 1'b1, "clr_coinc_udf");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr_udf");

`ifdef RAMFIFO_FWFT_EN
        do_reset("fwft_reset");
        step(1'b1, 8'hA5, 1'b0, 1'b0, "fwft_wr");
        step(1'b0, 8'h00, 1'b0, 1'b0, "fwft_n1");
        check("fwft_rdata", 32'(rdata), 32'h0000_00A5);
        check("fwft_not_empty", 32'(empty), 32'(0));
        step(1'b0, 8'h00, 1'b1, 1'b0, "fwft_pop");
        check("fwft_empty", 32'(empty), 32'(1));
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "fwft_b2b_wr");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "fwft_b2b_rd");
`endif

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
